// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, redirect and data-memory waits
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_stall,
   output logic             idex_flush,
   output logic             exmem_stall,
   output logic             memwb_flush,
   output logic             mem_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, HALT = 2'b10} st_t;
   st_t st, st_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic err_nxt, lu, mw, full, live, redir, lu_act;
   always_comb begin
      lu = ex_memread & ex_regwrite & (ex_rd != 5'd0) &
           ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
      mw = mem_req & ~mem_ready;
      full = (st == HALT) || (st == RUN && mw) || (st == MEM_WAIT && !mem_ready);
      // a released MEM_WAIT behaves like RUN without a memory wait
      live = ~full;
      redir = live & ex_redirect;
      lu_act = live & ~ex_redirect & lu;
      st_nxt = st;
      wait_nxt = wait_cnt;
      err_nxt = mem_err;
      if (st == RUN && mw) begin
         st_nxt = MEM_WAIT;
         wait_nxt = 8'd1;
      end else if (st == MEM_WAIT && mem_ready) begin
         st_nxt = RUN;
         wait_nxt = 8'd0;
      end else if (st == MEM_WAIT && wait_cnt == 8'(MEM_TIMEOUT)) begin
         st_nxt = HALT;
         err_nxt = 1'b1;
      end else if (st == MEM_WAIT) begin
         wait_nxt = wait_cnt + 8'd1;
      end
   end
   assign pc_stall    = ~rst & (full | lu_act);
   assign ifid_stall  = ~rst & (full | lu_act);
   assign ifid_flush  = ~rst & redir;
   assign idex_stall  = ~rst & full;
   assign idex_flush  = ~rst & (redir | lu_act);
   assign exmem_stall = ~rst & full;
   assign memwb_flush = ~rst & full;
   assign state = st;
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= RUN;
         wait_cnt <= 8'd0;
         mem_err <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         st <= st_nxt;
         wait_cnt <= wait_nxt;
         mem_err <= err_nxt;
         if (pc_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (ifid_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench; u0 has a short timeout, u1 has 3-bit counters
module tb_pipe_hazard_ctrl;
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] LU   = 7'b1100100;
   localparam logic [6:0] RD   = 7'b0010100;
   localparam logic [6:0] FULL = 7'b1101011;
   localparam logic [1:0] S_RUN = 2'b00, S_MW = 2'b01, S_HALT = 2'b10;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_regwrite = 0;
   logic ex_redirect = 0, mem_req = 0, mem_ready = 0;
   logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush;
   logic mem_err;
   logic [1:0] state;
   logic [31:0] stall_cnt, flush_cnt;
   logic b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_stall, b_idex_flush;
   logic b_exmem_stall, b_memwb_flush, b_mem_err;
   logic [1:0] b_state;
   logic [2:0] b_stall_cnt, b_flush_cnt;
   int n_cmp = 0, n_bad = 0;
   logic [8:0] exp_q[$];
   string tag_q[$];
   always #5 clk = ~clk;
   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) u0 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
      .memwb_flush(memwb_flush), .mem_err(mem_err), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
   pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(3)) u1 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush),
      .idex_stall(b_idex_stall), .idex_flush(b_idex_flush), .exmem_stall(b_exmem_stall),
      .memwb_flush(b_memwb_flush), .mem_err(b_mem_err), .state(b_state),
      .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // expected {outputs, state} for the current cycle; compared at the following negedge
   task automatic nxt(input string tag, input logic [6:0] o, input logic [1:0] st);
      exp_q.push_back({o, st});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      {id_rs1, id_rs2, ex_rd} = '0;
      {id_use_rs1, id_use_rs2, ex_memread, ex_regwrite, ex_redirect, mem_req, mem_ready} = '0;
   endtask
   task automatic lu_pat(input logic [4:0] r);
      ex_memread = 1; ex_regwrite = 1; ex_rd = r; id_rs2 = r; id_use_rs2 = 1;
   endtask
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         chk(tag_q.pop_front(),
             32'({pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
                  memwb_flush, state}),
             32'(exp_q.pop_front()));
      end
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      lu_pat(5'd5);
      nxt("rst_forces_zero", NONE, S_RUN);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_mem_err", 32'(mem_err), 0);
      rst = 0;
      nxt("lu_rs2", LU, S_RUN);
      ex_memread = 0;
      nxt("lu_cleared", NONE, S_RUN);
      chk("lu_stall_cnt", stall_cnt, 1);
      idle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1;
      nxt("lu_rs1", LU, S_RUN);
      idle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
      nxt("x0_no_hazard", NONE, S_RUN);
      idle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd3;
      id_use_rs2 = 1;
      nxt("unused_rs1", NONE, S_RUN);
      idle(); ex_memread = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1;
      nxt("no_regwrite", NONE, S_RUN);
      idle(); lu_pat(5'd5); ex_redirect = 1;
      nxt("redirect_beats_lu", RD, S_RUN);
      chk("redirect_flush_cnt", flush_cnt, 1);
      chk("redirect_stall_cnt", stall_cnt, 2);
      idle(); mem_req = 1; mem_ready = 1;
      nxt("mem_ready_same_cycle", NONE, S_RUN);
      mem_ready = 0;
      nxt("mw_enter", FULL, S_RUN);
      ex_redirect = 1;
      nxt("mw_redirect_held", FULL, S_MW);
      ex_redirect = 0;
      nxt("mw_hold", FULL, S_MW);
      mem_ready = 1; ex_redirect = 1;
      nxt("mw_release_redirect", RD, S_MW);
      idle();
      nxt("mw_back_run", NONE, S_RUN);
      chk("mw_stall_cnt", stall_cnt, 5);
      chk("mw_flush_cnt", flush_cnt, 2);
      mem_req = 1;
      nxt("mw2_enter", FULL, S_RUN);
      mem_ready = 1; lu_pat(5'd12);
      nxt("mw2_release_lu", LU, S_MW);
      idle();
      nxt("mw2_back_run", NONE, S_RUN);
      chk("mw2_stall_cnt", stall_cnt, 7);
      rst = 1;
      nxt("rst2", NONE, S_RUN);
      rst = 0; mem_req = 1;
      for (int i = 0; i < 10; i++)
         nxt("timeout_stall", FULL, i == 0 ? S_RUN : (i < 5 ? S_MW : S_HALT));
      chk("timeout_state", 32'(state), 32'(S_HALT));
      chk("timeout_mem_err", 32'(mem_err), 1);
      chk("timeout_stall_cnt", stall_cnt, 10);
      chk("sat_stall_cnt", 32'(b_stall_cnt), 7);
      chk("sat_state", 32'(b_state), 32'(S_MW));
      chk("sat_mem_err", 32'(b_mem_err), 0);
      mem_req = 0; mem_ready = 1; ex_redirect = 1;
      nxt("halt_ignores_inputs", FULL, S_HALT);
      rst = 1;
      nxt("rst_in_halt", NONE, S_HALT);
      chk("halt_rst_state", 32'(state), 32'(S_RUN));
      chk("halt_rst_mem_err", 32'(mem_err), 0);
      chk("halt_rst_stall_cnt", stall_cnt, 0);
      chk("halt_rst_flush_cnt", flush_cnt, 0);
      chk("mw_rst_state", 32'(b_state), 32'(S_RUN));
      chk("mw_rst_stall_cnt", 32'(b_stall_cnt), 0);
      rst = 0; idle();
      nxt("after_rst", NONE, S_RUN);
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
